btn_conditioner: RTL
====================

# btn_conditioner

Input conditioning stage between the raw board push-buttons and the `genius` game core. Each button passes through a two-flop synchronizer, a per-button debounce filter and an edge detector. The stage produces single-cycle press and release pulses, a debounced level, and an encoded "exactly one new press" event that the game FSM consumes for sequence entry and start. Inputs are asynchronous, noisy, bouncing contacts; every output is registered and glitch-free in the `clock` domain.

## Interface
- `N_BTN`, default 4: number of buttons (bits 0-2 are game buttons `btn0..btn2`, bit 3 is `start`).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range is ≥1.
- `ACTIVE_LOW`, default 0: 1 inverts `btn_raw` after synchronization (board keys are pressed = 0).
- `IDX_W`, default `$clog2(N_BTN)` (minimum 1): width of `press_idx`.
- `clock` input, 1 bit: single clock for the block, rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `btn_raw` input, `N_BTN` bits: raw button pins, asynchronous.
- `enable` input, 1 bit: when 0, all pulse outputs are suppressed; level tracking continues.
- `btn_level` output, `N_BTN` bits: debounced level, 1 = pressed.
- `press_pulse` output, `N_BTN` bits: one-cycle pulse on debounced 0→1.
- `release_pulse` output, `N_BTN` bits: one-cycle pulse on debounced 1→0.
- `press_valid` output, 1 bit: one-cycle pulse for a clean single press.
- `press_idx` output, `IDX_W` bits: index of the pressed button, valid while `press_valid`=1.
- `multi_press` output, 1 bit: one-cycle pulse when a new press is rejected as ambiguous.

## Operation
- **Synchronizer:** per bit, two flops `s1`→`s2`. If `ACTIVE_LOW`=1, the filter sees `~s2`; otherwise it sees `s2`. Call this value `s`.
- **Debounce:** per button, register `stable` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - `s == stable`: `cnt` ← 0.
  - `s != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - `s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s`, `cnt` ← 0.
  - A mismatch shorter than `DEBOUNCE_CYCLES` cycles (bounce or glitch) leaves `stable` unchanged.
- **Levels and pulses:** `btn_level` = `stable`. On the edge where `stable` updates, the corresponding `press_pulse`/`release_pulse` bit is registered high for exactly one cycle, gated by `enable`.
- **Encoder:** evaluated on the same edge, from the `stable` value before the update ("prev") and the new press set P.
  - **Clean press:** `press_valid` ← 1 and `press_idx` ← i when all of these hold: P = {i} (exactly one bit), every other prev bit is 0, and `enable`=1.
  - **Ambiguous press:** `multi_press` ← 1 when P is non-empty, the clean-press condition fails, and `enable`=1.
  - **Hold value:** `press_idx` holds its last value when `press_valid`=0.
- Release events never drive `press_valid` or `multi_press`.
- **`enable` mid-debounce:** the counter keeps running. If `enable` is low on the update edge, that event is lost and is not replayed when `enable` rises.

## Timing
- **Reset values:** all outputs 0; `s1`, `s2`, `stable` and `cnt` are 0 at the inactive level (after the `ACTIVE_LOW` mapping).
- **Press latency:** take `btn_raw` as sampled active at edge 0 and clean afterwards. `s` becomes active after edge 1, and `press_pulse`/`press_valid` are high in the cycle after edge `DEBOUNCE_CYCLES`+1. Release latency is identical.
- **Button held through reset:** once `reset` deasserts, the button is reported as a press after the normal latency.
- **Reset mid-debounce:** counters and pulses clear immediately (asynchronous); no partial event survives.
- **Simultaneous updates:** several buttons may pulse on the same edge. `press_pulse` shows every bit, while the encoder reports `multi_press`.
- **Counter width:** the counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around occurs.
- **Re-triggering:** a new press on a button needs an intervening debounced release; holding a button produces no repeat pulses.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=0.
- **Clean press:** `btn_raw`=0001 held for 10 cycles → `press_pulse`=0001, `press_valid`=1 and `press_idx`=0 for exactly one cycle, 6 edges after first sample; `btn_level[0]`=1.
- **Bounce rejection:** `btn_raw[1]` toggles every 2 cycles for 20 cycles, then settles at 1 → no pulse during toggling. Exactly one `press_valid` with `press_idx`=1, 6 edges after the settling sample.
- **Simultaneous press:** `btn_raw` goes 0000→0101 at the same edge → `press_pulse`=0101 and `multi_press`=1 for one cycle; `press_valid` stays 0.
- **Press while another is held:** `btn2` is held (debounced), then `btn0` is pressed → `multi_press`=1 and `press_valid`=0. Releasing `btn2` gives `release_pulse`=0100 and `press_valid` stays 0.
- **Gating and release:** with `enable`=0, press and release `btn3` → `btn_level[3]` follows (1, then 0) and no pulses appear. With `enable`=1, pressing `btn3` gives `press_idx`=3.
- **Reset mid-debounce:** assert `reset` 2 cycles into a `btn0` press → all outputs 0 at once. After release of `reset` with the button still held, `press_valid` fires with `press_idx`=0 after 6 edges.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects the raw board
// push-buttons, and encodes a clean single new press for the game core.
// Every output comes straight from a flop in the clock domain.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ACTIVE_LOW      = 0,
    parameter int IDX_W           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             multi_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw pin value that means "not pressed", so a held key is seen as a
    // fresh press once reset is released.
    localparam logic [N_BTN-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    logic [N_BTN-1:0] s1_r;
    logic [N_BTN-1:0] s2_r;
    logic [N_BTN-1:0] s_s;
    logic [N_BTN-1:0] stable_r;
    logic [CNT_W-1:0] cnt_r     [N_BTN];
    logic [CNT_W-1:0] cnt_nxt_s [N_BTN];
    logic [N_BTN-1:0] update_s;
    logic [N_BTN-1:0] stable_nxt_s;
    logic [N_BTN-1:0] rise_s;
    logic [N_BTN-1:0] fall_s;
    logic             onehot_s;
    logic             clean_s;
    logic [IDX_W-1:0] idx_s;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_r <= IDLE_RAW;
            s2_r <= IDLE_RAW;
        end else begin
            s1_r <= btn_raw;
            s2_r <= s1_r;
        end
    end

    // Polarity mapping so that 1 always means pressed downstream.
    always_comb begin
        s_s = s2_r;
        if (ACTIVE_LOW != 0) begin
            s_s = ~s2_r;
        end else begin
            s_s = s2_r;
        end
    end

    // Debounce counters: a mismatch must persist DEBOUNCE_CYCLES cycles to be accepted.
    always_comb begin
        update_s = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (s_s[i] != stable_r[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    update_s[i]  = 1'b1;
                    cnt_nxt_s[i] = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
                end
            end else begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end
        end
        stable_nxt_s = stable_r ^ update_s;
        rise_s       = update_s & s_s;
        fall_s       = update_s & ~s_s;
    end

    // Encoder: a clean press is one rising button while nothing else is held.
    always_comb begin
        onehot_s = (rise_s != {N_BTN{1'b0}}) && ((rise_s & (rise_s - N_BTN'(1))) == {N_BTN{1'b0}});
        clean_s  = onehot_s && (stable_r == {N_BTN{1'b0}});
        idx_s    = {IDX_W{1'b0}};
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise_s[i]) begin
                idx_s = IDX_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Debounced state and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_r <= {N_BTN{1'b0}};
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Registered pulse and encoder outputs; events on a disabled edge are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_pulse   <= {N_BTN{1'b0}};
            release_pulse <= {N_BTN{1'b0}};
            press_valid   <= 1'b0;
            press_idx     <= {IDX_W{1'b0}};
            multi_press   <= 1'b0;
        end else begin
            if (enable) begin
                press_pulse   <= rise_s;
                release_pulse <= fall_s;
                press_valid   <= clean_s;
                multi_press   <= (rise_s != {N_BTN{1'b0}}) && !clean_s;
                if (clean_s) begin
                    press_idx <= idx_s;
                end else begin
                    press_idx <= press_idx;
                end
            end else begin
                press_pulse   <= {N_BTN{1'b0}};
                release_pulse <= {N_BTN{1'b0}};
                press_valid   <= 1'b0;
                multi_press   <= 1'b0;
                press_idx     <= press_idx;
            end
        end
    end

    assign btn_level = stable_r;

endmodule
